// File: rtl/mul_seq_if.sv
// CPU-side interface of the sequential multiplier: start/operand request
// plus busy/done status and the registered product with its flags.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 hi_nz;
  logic                 zero;

  // CPU side: issues requests, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, product, hi_nz, zero
  );

  // Multiplier side: accepts requests, reports status and result
  modport slave (
    input  start, a, b,
    output busy, done, product, hi_nz, zero
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier controller. One add/shift step
// per clock through an external combinational adder; the carry-out of that
// adder is shifted into the top of the high product half so the all-ones
// case is exact. Fixed latency of WIDTH+1 cycles from accepted start to done.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_seq_if.slave         bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_f,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Count value of the final add/shift step
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_p_hi_nxt;
  logic [WIDTH-1:0] w_p_lo_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Adder operands: accumulate the multiplicand only when the current
  // multiplier bit (p_lo[0]) is set, otherwise the step is a pure shift
  assign add_a   = r_p_hi;
  assign add_b   = r_p_lo[0] ? r_mcand : {WIDTH{1'b0}};
  assign add_cin = 1'b0;

  // Status and result decoded straight from registers
  assign bus.busy    = (r_state == ST_CALC);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.product = {r_p_hi, r_p_lo};
  assign bus.hi_nz   = |r_p_hi;
  assign bus.zero    = ~(|{r_p_hi, r_p_lo});

  // Next-state and datapath next values; hold everything by default
  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_p_hi_nxt  = r_p_hi;
    w_p_lo_nxt  = r_p_lo;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mcand_nxt = bus.a;
          w_p_hi_nxt  = {WIDTH{1'b0}};
          w_p_lo_nxt  = bus.b;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        // {cout, sum, p_lo} shifted right by one
        {w_p_hi_nxt, w_p_lo_nxt} = {add_cout, add_f, r_p_lo[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_DONE: begin
        // start is ignored here; always return to IDLE
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand <= {WIDTH{1'b0}};
      r_p_hi  <= {WIDTH{1'b0}};
      r_p_lo  <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_mcand <= w_mcand_nxt;
      r_p_hi  <= w_p_hi_nxt;
      r_p_lo  <= w_p_lo_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
